// File: rtl/m2_cs.sv
// m2_cs: second IDCT matrix stage. Computes S = Ct x T for one 8x8 block, reading T and packed C
// from DPRAMs, using three shared multipliers, and writing clipped 8-bit S pixels in pairs.
module m2_cs #(
   parameter int CS_DIVISOR = 16,
   parameter int CLIP_MAX   = 255
) (
   input  logic        CLOCK_50,
   input  logic        Resetn,
   input  logic        Start,
   input  logic [31:0] read_data_T_a,
   input  logic [31:0] read_data_T_b,
   input  logic [31:0] read_data_C_a,
   input  logic [31:0] read_data_C_b,
   input  logic [31:0] M1,
   input  logic [31:0] M2,
   input  logic [31:0] M3,
   output logic [31:0] M1_op1,
   output logic [31:0] M1_op2,
   output logic [31:0] M2_op1,
   output logic [31:0] M2_op2,
   output logic [31:0] M3_op1,
   output logic [31:0] M3_op2,
   output logic [6:0]  address_T_a,
   output logic [6:0]  address_T_b,
   output logic [6:0]  address_C_a,
   output logic [6:0]  address_C_b,
   output logic [6:0]  address_S,
   output logic [31:0] write_data_S,
   output logic        wren_S,
   output logic        Done,
   output logic [2:0]  o_dbg_state
);

   // Handshake: Start is a level request accepted only in S_IDLE; Done is a one-cycle pulse
   // that follows the 32nd S write, after which the FSM is back in S_IDLE.
   typedef enum logic [2:0] {
      S_IDLE, S_LEAD, S_LOOP0, S_LOOP1, S_LOOP2, S_DRAIN, S_DONE
   } state_t;

   state_t      r_state, w_state_n;
   logic [5:0]  r_e, w_e_n;
   logic [2:0]  w_i, w_j;
   logic        w_iss_v, w_iss_pre;
   logic [1:0]  w_iss_ph;
   logic [6:0]  w_addr_ta_n, w_addr_tb_n, w_addr_ca_n, w_addr_cb_n;

   logic        r_rd0_v, r_rd0_pre, r_rd1_v, r_rd1_pre, r_mul_v;
   logic [1:0]  r_rd0_ph, r_rd1_ph, r_mul_ph;
   logic [5:0]  r_rd0_e, r_rd1_e, r_mul_e;

   logic [31:0] r_t0 [8];
   logic [31:0] r_t1 [8];
   logic [31:0] r_acc;
   logic [7:0]  r_buf;

   logic [31:0]        w_ca_hi, w_ca_lo, w_cb_hi, w_cb_lo;
   logic [31:0]        w_sum;
   logic signed [31:0] w_shift;
   logic [7:0]         w_pix;

   assign w_i         = r_e[5:3];
   assign w_j         = r_e[2:0];
   assign Done        = (r_state == S_DONE);
   assign o_dbg_state = r_state;

   // Element (i,j) loop: each phase reads two T rows; rows 0/1 of T are cached in the lead-in
   // so 8 products fit in three cycles. C words 4i..4i+3 are re-read alongside T.
   always_comb begin
      w_state_n   = r_state;
      w_e_n       = r_e;
      w_iss_v     = 1'b0;
      w_iss_pre   = 1'b0;
      w_iss_ph    = 2'd0;
      w_addr_ta_n = address_T_a;
      w_addr_tb_n = address_T_b;
      w_addr_ca_n = address_C_a;
      w_addr_cb_n = address_C_b;
      case (r_state)
         S_IDLE: begin
            w_e_n = 6'd0;
            if (Start && !Done) begin
               w_iss_v     = 1'b1;
               w_iss_pre   = 1'b1;
               w_addr_ta_n = 7'd0;
               w_addr_tb_n = 7'd8;
               w_e_n       = 6'd1;
               w_state_n   = S_LEAD;
            end
         end
         S_LEAD: begin
            w_iss_v     = 1'b1;
            w_iss_pre   = 1'b1;
            w_addr_ta_n = {4'd0, w_j};
            w_addr_tb_n = {4'd1, w_j};
            if (w_j == 3'd7) begin
               w_e_n     = 6'd0;
               w_state_n = S_LOOP0;
            end else begin
               w_e_n = r_e + 6'd1;
            end
         end
         S_LOOP0: begin
            w_iss_v     = 1'b1;
            w_iss_ph    = 2'd0;
            w_addr_ta_n = {1'b0, 3'd2, w_j};
            w_addr_tb_n = {1'b0, 3'd3, w_j};
            w_addr_ca_n = {2'b00, w_i, 2'd1};
            w_addr_cb_n = {2'b00, w_i, 2'd0};
            w_state_n   = S_LOOP1;
         end
         S_LOOP1: begin
            w_iss_v     = 1'b1;
            w_iss_ph    = 2'd1;
            w_addr_ta_n = {1'b0, 3'd4, w_j};
            w_addr_tb_n = {1'b0, 3'd5, w_j};
            w_addr_ca_n = {2'b00, w_i, 2'd2};
            w_addr_cb_n = {2'b00, w_i, 2'd0};
            w_state_n   = S_LOOP2;
         end
         S_LOOP2: begin
            w_iss_v     = 1'b1;
            w_iss_ph    = 2'd2;
            w_addr_ta_n = {1'b0, 3'd6, w_j};
            w_addr_tb_n = {1'b0, 3'd7, w_j};
            w_addr_ca_n = {2'b00, w_i, 2'd3};
            w_addr_cb_n = {2'b00, w_i, 2'd0};
            w_e_n       = r_e + 6'd1;
            w_state_n   = (r_e == 6'd63) ? S_DRAIN : S_LOOP0;
         end
         S_DRAIN: begin
            if (wren_S && (address_S == 7'd31)) w_state_n = S_DONE;
         end
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_state     <= S_IDLE;
         r_e         <= 6'd0;
         address_T_a <= 7'd0;
         address_T_b <= 7'd0;
         address_C_a <= 7'd0;
         address_C_b <= 7'd0;
         r_rd0_v     <= 1'b0;
         r_rd0_pre   <= 1'b0;
         r_rd0_ph    <= 2'd0;
         r_rd0_e     <= 6'd0;
         r_rd1_v     <= 1'b0;
         r_rd1_pre   <= 1'b0;
         r_rd1_ph    <= 2'd0;
         r_rd1_e     <= 6'd0;
      end else begin
         r_state     <= w_state_n;
         r_e         <= w_e_n;
         address_T_a <= w_addr_ta_n;
         address_T_b <= w_addr_tb_n;
         address_C_a <= w_addr_ca_n;
         address_C_b <= w_addr_cb_n;
         r_rd0_v     <= w_iss_v;
         r_rd0_pre   <= w_iss_pre;
         r_rd0_ph    <= w_iss_ph;
         r_rd0_e     <= r_e;
         r_rd1_v     <= r_rd0_v;
         r_rd1_pre   <= r_rd0_pre;
         r_rd1_ph    <= r_rd0_ph;
         r_rd1_e     <= r_rd0_e;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (r_rd1_v && r_rd1_pre) begin
         r_t0[r_rd1_e[2:0]] <= read_data_T_a;
         r_t1[r_rd1_e[2:0]] <= read_data_T_b;
      end
   end

   assign w_ca_hi = {{16{read_data_C_a[31]}}, read_data_C_a[31:16]};
   assign w_ca_lo = {{16{read_data_C_a[15]}}, read_data_C_a[15:0]};
   assign w_cb_hi = {{16{read_data_C_b[31]}}, read_data_C_b[31:16]};
   assign w_cb_lo = {{16{read_data_C_b[15]}}, read_data_C_b[15:0]};

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         M1_op1   <= 32'd0;
         M1_op2   <= 32'd0;
         M2_op1   <= 32'd0;
         M2_op2   <= 32'd0;
         M3_op1   <= 32'd0;
         M3_op2   <= 32'd0;
         r_mul_v  <= 1'b0;
         r_mul_ph <= 2'd0;
         r_mul_e  <= 6'd0;
      end else begin
         r_mul_v  <= r_rd1_v && !r_rd1_pre;
         r_mul_ph <= r_rd1_ph;
         r_mul_e  <= r_rd1_e;
         if (r_rd1_v && !r_rd1_pre) begin
            M1_op1 <= w_ca_hi;
            M1_op2 <= read_data_T_a;
            M2_op1 <= w_ca_lo;
            M2_op2 <= read_data_T_b;
            if (r_rd1_ph == 2'd0) begin
               M3_op1 <= w_cb_hi;
               M3_op2 <= r_t0[r_rd1_e[2:0]];
            end else if (r_rd1_ph == 2'd1) begin
               M3_op1 <= w_cb_lo;
               M3_op2 <= r_t1[r_rd1_e[2:0]];
            end
         end
      end
   end

   // Final phase has only two live products; M3 is left out of the sum.
   assign w_sum   = r_acc + M1 + M2;
   assign w_shift = $signed(w_sum) >>> CS_DIVISOR;

   always_comb begin
      if (w_shift < 0)             w_pix = 8'd0;
      else if (w_shift > CLIP_MAX) w_pix = 8'(CLIP_MAX);
      else                         w_pix = w_shift[7:0];
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_acc        <= 32'd0;
         r_buf        <= 8'd0;
         wren_S       <= 1'b0;
         address_S    <= 7'd0;
         write_data_S <= 32'd0;
      end else begin
         wren_S <= 1'b0;
         if (r_mul_v) begin
            case (r_mul_ph)
               2'd0:    r_acc <= M1 + M2 + M3;
               2'd1:    r_acc <= r_acc + M1 + M2 + M3;
               default: begin
                  if (!r_mul_e[0]) begin
                     r_buf <= w_pix;
                  end else begin
                     wren_S       <= 1'b1;
                     address_S    <= {2'b00, r_mul_e[5:3], r_mul_e[2:1]};
                     write_data_S <= {16'd0, r_buf, w_pix};
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_m2_cs.sv
// Bench for m2_cs: DPRAM and multiplier models, per-scenario tasks, expected-word scoreboard.
`timescale 1ns/1ps
module tb_m2_cs;

   logic        CLOCK_50 = 1'b0;
   logic        Resetn   = 1'b0;
   logic        Start    = 1'b0;
   logic [31:0] read_data_T_a, read_data_T_b, read_data_C_a, read_data_C_b;
   logic [31:0] M1, M2, M3;
   logic [31:0] M1_op1, M1_op2, M2_op1, M2_op2, M3_op1, M3_op2;
   logic [6:0]  address_T_a, address_T_b, address_C_a, address_C_b, address_S;
   logic [31:0] write_data_S;
   logic        wren_S, Done;
   logic [2:0]  o_dbg_state;

   logic [31:0]        t_mem [128];
   logic [31:0]        c_mem [128];
   logic signed [15:0] c_mat [8][8];
   logic signed [31:0] t_mat [8][8];
   logic [38:0]        exp_q [$];
   logic [38:0]        obs_q [$];
   int                 n_cmp = 0;
   int                 n_bad = 0;

   m2_cs dut (
      .CLOCK_50(CLOCK_50), .Resetn(Resetn), .Start(Start),
      .read_data_T_a(read_data_T_a), .read_data_T_b(read_data_T_b),
      .read_data_C_a(read_data_C_a), .read_data_C_b(read_data_C_b),
      .M1(M1), .M2(M2), .M3(M3),
      .M1_op1(M1_op1), .M1_op2(M1_op2), .M2_op1(M2_op1), .M2_op2(M2_op2),
      .M3_op1(M3_op1), .M3_op2(M3_op2),
      .address_T_a(address_T_a), .address_T_b(address_T_b),
      .address_C_a(address_C_a), .address_C_b(address_C_b),
      .address_S(address_S), .write_data_S(write_data_S), .wren_S(wren_S),
      .Done(Done), .o_dbg_state(o_dbg_state)
   );

   // clock / memories / multipliers
   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      read_data_T_a <= t_mem[address_T_a];
      read_data_T_b <= t_mem[address_T_b];
      read_data_C_a <= c_mem[address_C_a];
      read_data_C_b <= c_mem[address_C_b];
   end

   assign M1 = M1_op1 * M1_op2;
   assign M2 = M2_op1 * M2_op2;
   assign M3 = M3_op1 * M3_op2;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // stimulus helpers
   task automatic load_mems();
      for (int i = 0; i < 128; i++) begin
         t_mem[i] = 32'd0;
         c_mem[i] = 32'd0;
      end
      for (int i = 0; i < 8; i++)
         for (int m = 0; m < 4; m++)
            c_mem[4*i+m] = {c_mat[2*m][i], c_mat[2*m+1][i]};
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 8; j++)
            t_mem[8*k+j] = t_mat[k][j];
   endtask

   task automatic set_c_diag(input logic signed [15:0] v);
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < 8; i++)
            c_mat[k][i] = (k == i) ? v : 16'sd0;
   endtask

   task automatic set_c_all(input logic signed [15:0] v);
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < 8; i++)
            c_mat[k][i] = v;
   endtask

   task automatic set_t_all(input logic signed [31:0] v);
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 8; j++)
            t_mat[k][j] = v;
   endtask

   task automatic set_t_ramp();
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 8; j++)
            t_mat[k][j] = 4 * (8 * k + j);
   endtask

   task automatic push_const(input logic [31:0] w);
      for (int a = 0; a < 32; a++) exp_q.push_back({7'(a), w});
   endtask

   task automatic push_ramp();
      for (int a = 0; a < 32; a++) exp_q.push_back({7'(a), 16'd0, 8'(2 * a), 8'(2 * a + 1)});
   endtask

   function automatic logic [7:0] model_pix(input int i, input int j);
      logic signed [31:0] acc;
      logic signed [31:0] prod;
      logic signed [31:0] sh;
      acc = 32'sd0;
      for (int k = 0; k < 8; k++) begin
         prod = c_mat[k][i] * t_mat[k][j];
         acc  = acc + prod;
      end
      sh = acc >>> 16;
      if (sh < 0)        return 8'd0;
      else if (sh > 255) return 8'd255;
      else               return sh[7:0];
   endfunction

   task automatic push_model();
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j += 2)
            exp_q.push_back({7'(4 * i + j / 2), 16'd0, model_pix(i, j), model_pix(i, j + 1)});
   endtask

   // driver: raises Start, records writes/Done; lat = edges after the Start-sampling edge
   task automatic run_block(input bit hold, output int n_wr, output int n_done, output int lat);
      int cyc;
      int tail;
      obs_q.delete();
      n_wr   = 0;
      n_done = 0;
      lat    = -1;
      tail   = -1;
      cyc    = 0;
      @(negedge CLOCK_50);
      Start = 1'b1;
      while (cyc < 400) begin
         @(negedge CLOCK_50);
         cyc++;
         if (wren_S) begin
            obs_q.push_back({address_S, write_data_S});
            n_wr++;
         end
         if (Done) begin
            n_done++;
            if (lat < 0) begin
               lat = cyc - 1;
               if (hold) break;
               Start = 1'b0;
               tail  = cyc + 5;
            end
         end
         if (tail >= 0 && cyc >= tail) break;
      end
      if (!hold) Start = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      Resetn = 1'b0;
      Start  = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      n_cmp++; if (wren_S !== 1'b0) begin n_bad++; $display("FAIL reset_wren: got %b want 0", wren_S); end
      n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", Done); end
      n_cmp++; if ({address_S, write_data_S} !== 39'd0) begin n_bad++; $display("FAIL reset_s: got %h/%h want 0", address_S, write_data_S); end
      n_cmp++; if ({address_T_a, address_T_b, address_C_a, address_C_b} !== 28'd0) begin
         n_bad++; $display("FAIL reset_addr: got %h want 0", {address_T_a, address_T_b, address_C_a, address_C_b}); end
      n_cmp++; if ({M1_op1, M1_op2, M2_op1, M2_op2, M3_op1, M3_op2} !== 192'd0) begin
         n_bad++; $display("FAIL reset_ops: got %h want 0", {M1_op1, M1_op2, M2_op1, M2_op2, M3_op1, M3_op2}); end
      n_cmp++; if (o_dbg_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_dbg_state); end
      @(negedge CLOCK_50);
      Resetn = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      n_cmp++; if (wren_S !== 1'b0 || Done !== 1'b0) begin n_bad++; $display("FAIL idle_quiet: got wren=%b done=%b want 0 0", wren_S, Done); end
   endtask

   task automatic test_identity();
      int n_wr, n_done, lat;
      logic [38:0] o, e;
      set_c_diag(16'sd16384); set_t_all(32'sd400); load_mems();
      push_const(32'h0000_6464);
      run_block(1'b0, n_wr, n_done, lat);
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); n_cmp++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7f_ffff_ffff;
         if (o !== e) begin n_bad++; $display("FAIL ident_word: got %0d:%h want %0d:%h", o[38:32], o[31:0], e[38:32], e[31:0]); end
      end
      n_cmp++; if (n_wr != 32) begin n_bad++; $display("FAIL ident_nwr: got %0d want 32", n_wr); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL ident_done: got %0d want 1", n_done); end
      n_cmp++; if (lat < 0 || lat > 204) begin n_bad++; $display("FAIL ident_lat: got %0d want 0..204", lat); end
      exp_q.delete();
   endtask

   task automatic test_uniform();
      int n_wr, n_done, lat;
      logic [38:0] o, e;
      set_c_all(16'sd8192); set_t_all(32'sd100); load_mems();
      push_const(32'h0000_6464);
      run_block(1'b0, n_wr, n_done, lat);
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); n_cmp++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7f_ffff_ffff;
         if (o !== e) begin n_bad++; $display("FAIL unif_word: got %0d:%h want %0d:%h", o[38:32], o[31:0], e[38:32], e[31:0]); end
      end
      n_cmp++; if (n_wr != 32) begin n_bad++; $display("FAIL unif_nwr: got %0d want 32", n_wr); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL unif_done: got %0d want 1", n_done); end
      exp_q.delete();
   endtask

   task automatic test_clip();
      int n_wr, n_done, lat;
      logic [38:0] o, e;
      for (int b = 0; b < 2; b++) begin
         set_c_diag(16'sd16384);
         set_t_all((b == 0) ? -32'sd400 : 32'sd4000);
         load_mems();
         push_const((b == 0) ? 32'h0000_0000 : 32'h0000_ffff);
         run_block(1'b0, n_wr, n_done, lat);
         while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7f_ffff_ffff;
            if (o !== e) begin n_bad++; $display("FAIL clip%0d_word: got %0d:%h want %0d:%h", b, o[38:32], o[31:0], e[38:32], e[31:0]); end
         end
         n_cmp++; if (n_wr != 32) begin n_bad++; $display("FAIL clip%0d_nwr: got %0d want 32", b, n_wr); end
         n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL clip%0d_done: got %0d want 1", b, n_done); end
         exp_q.delete();
      end
   endtask

   task automatic test_ordering();
      int n_wr, n_done, lat;
      logic [38:0] o, e;
      set_c_diag(16'sd16384); set_t_ramp(); load_mems();
      push_ramp();
      run_block(1'b0, n_wr, n_done, lat);
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); n_cmp++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7f_ffff_ffff;
         if (o !== e) begin n_bad++; $display("FAIL order_word: got %0d:%h want %0d:%h", o[38:32], o[31:0], e[38:32], e[31:0]); end
      end
      n_cmp++; if (n_wr != 32) begin n_bad++; $display("FAIL order_nwr: got %0d want 32", n_wr); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL order_done: got %0d want 1", n_done); end
      exp_q.delete();
   endtask

   task automatic test_random();
      int n_wr, n_done, lat, tmp;
      logic [38:0] o, e;
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 8; k++)
            for (int x = 0; x < 8; x++) begin
               tmp = int'($urandom_range(0, 32767)) - 16384;
               c_mat[k][x] = 16'(tmp);
               if (b == 0) tmp = int'($urandom_range(0, 65535)) - 32768;
               else        tmp = int'($urandom_range(0, 255));
               t_mat[k][x] = tmp;
            end
         load_mems();
         push_model();
         run_block(1'b0, n_wr, n_done, lat);
         while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7f_ffff_ffff;
            if (o !== e) begin n_bad++; $display("FAIL rand%0d_word: got %0d:%h want %0d:%h", b, o[38:32], o[31:0], e[38:32], e[31:0]); end
         end
         n_cmp++; if (n_wr != 32) begin n_bad++; $display("FAIL rand%0d_nwr: got %0d want 32", b, n_wr); end
         n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL rand%0d_done: got %0d want 1", b, n_done); end
         n_cmp++; if (lat < 0 || lat > 204) begin n_bad++; $display("FAIL rand%0d_lat: got %0d want 0..204", b, lat); end
         exp_q.delete();
      end
   endtask

   task automatic test_abort();
      int n_wr, n_done, lat, wr_after, done_after;
      logic [38:0] o, e;
      set_c_diag(16'sd16384); set_t_ramp(); load_mems();
      @(negedge CLOCK_50);
      Start = 1'b1;
      repeat (50) @(negedge CLOCK_50);
      Resetn = 1'b0;
      Start  = 1'b0;
      #1;
      n_cmp++; if ({wren_S, Done, address_S, write_data_S} !== 41'd0) begin
         n_bad++; $display("FAIL abort_sout: got %h want 0", {wren_S, Done, address_S, write_data_S}); end
      n_cmp++; if ({address_T_a, address_T_b, address_C_a, address_C_b, M1_op1, M3_op2} !== 92'd0) begin
         n_bad++; $display("FAIL abort_rd: got %h want 0", {address_T_a, address_T_b, address_C_a, address_C_b, M1_op1, M3_op2}); end
      n_cmp++; if (o_dbg_state !== 3'd0) begin n_bad++; $display("FAIL abort_state: got %0d want 0", o_dbg_state); end
      repeat (2) @(negedge CLOCK_50);
      Resetn     = 1'b1;
      wr_after   = 0;
      done_after = 0;
      repeat (40) begin
         @(negedge CLOCK_50);
         if (wren_S) wr_after++;
         if (Done) done_after++;
      end
      n_cmp++; if (wr_after != 0) begin n_bad++; $display("FAIL abort_writes: got %0d want 0", wr_after); end
      n_cmp++; if (done_after != 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", done_after); end
      push_ramp();
      run_block(1'b0, n_wr, n_done, lat);
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); n_cmp++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7f_ffff_ffff;
         if (o !== e) begin n_bad++; $display("FAIL after_abort_word: got %0d:%h want %0d:%h", o[38:32], o[31:0], e[38:32], e[31:0]); end
      end
      n_cmp++; if (n_wr != 32) begin n_bad++; $display("FAIL after_abort_nwr: got %0d want 32", n_wr); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL after_abort_done: got %0d want 1", n_done); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int n_wr, n_done, lat;
      logic [38:0] o, e;
      set_c_diag(16'sd16384); set_t_ramp(); load_mems();
      for (int b = 0; b < 2; b++) begin
         push_ramp();
         run_block(b == 0, n_wr, n_done, lat);
         while (obs_q.size() != 0) begin
            o = obs_q.pop_front(); n_cmp++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7f_ffff_ffff;
            if (o !== e) begin n_bad++; $display("FAIL b2b%0d_word: got %0d:%h want %0d:%h", b, o[38:32], o[31:0], e[38:32], e[31:0]); end
         end
         n_cmp++; if (n_wr != 32) begin n_bad++; $display("FAIL b2b%0d_nwr: got %0d want 32", b, n_wr); end
         n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL b2b%0d_done: got %0d want 1", b, n_done); end
         n_cmp++; if (lat < 0 || lat > 204) begin n_bad++; $display("FAIL b2b%0d_lat: got %0d want 0..204", b, lat); end
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_uniform();
      test_clip();
      test_ordering();
      test_random();
      test_abort();
      test_back_to_back();
      repeat (2) @(negedge CLOCK_50);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
